// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on request, aligns to the camera's end-of-frame,
// writes in-range pixels into one of two banks and publishes complete frames by bank swap.
module frame_capture_ctrl #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240
) (
  input  logic        system_clk_in,
  input  logic        rst_n_in,
  input  logic        capture_req_in,
  input  logic        continuous_in,
  input  logic        frame_done_in,
  input  logic        data_valid_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [15:0] pixel_in,
  input  logic        rd_lock_in,
  output logic        wr_en_out,
  output logic        wr_bank_out,
  output logic [16:0] wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        rd_bank_out,
  output logic        frame_ready_out,
  output logic        busy_out,
  output logic [7:0]  drop_count_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    PUBLISH  = 2'd3
  } state_t;

  localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM     = 10'(V_ACTIVE);
  localparam logic [16:0] H_MUL     = 17'(H_ACTIVE);
  localparam logic [16:0] FRAME_PIX = 17'(H_ACTIVE * V_ACTIVE);

  logic        rst_sync_q;
  logic        rst_int_n;

  state_t      state_q,       state_d;
  logic [16:0] pix_cnt_q,     pix_cnt_d;
  logic        wr_en_q,       wr_en_d;
  logic [16:0] wr_addr_q,     wr_addr_d;
  logic [15:0] wr_data_q,     wr_data_d;
  logic        wr_bank_q,     wr_bank_d;
  logic        rd_bank_q,     rd_bank_d;
  logic        frame_ready_q, frame_ready_d;
  logic        busy_q,        busy_d;
  logic [7:0]  drop_count_q,  drop_count_d;

  logic        in_range;
  logic [16:0] pix_addr;

  // Assertion is immediate; release passes through one flop so the FSM first
  // moves on the second clock edge after rst_n_in rises.
  always_ff @(posedge system_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= 1'b0;
    else           rst_sync_q <= 1'b1;
  end

  assign rst_int_n = rst_sync_q;

  assign in_range = (hcount_in < H_LIM) && (vcount_in < V_LIM);
  assign pix_addr = 17'(vcount_in) * H_MUL + 17'(hcount_in);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_ready_d = 1'b0;
    drop_count_d  = drop_count_q;

    case (state_q)
      IDLE: begin
        if (capture_req_in) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (frame_done_in) begin
          state_d   = CAPTURE;
          pix_cnt_d = '0;
        end
      end
      CAPTURE: begin
        // End of frame takes priority over a coincident pixel.
        if (frame_done_in) begin
          state_d = PUBLISH;
        end else if (data_valid_in && in_range) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_addr;
          wr_data_d = pixel_in;
          if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 17'd1;
        end
      end
      PUBLISH: begin
        if ((pix_cnt_q == FRAME_PIX) && !rd_lock_in) begin
          rd_bank_d     = wr_bank_q;
          wr_bank_d     = ~wr_bank_q;
          frame_ready_d = 1'b1;
        end else if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
        if (continuous_in) begin
          state_d   = CAPTURE;
          pix_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_SOF) || (state_d == CAPTURE);
  end

  always_ff @(posedge system_clk_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign wr_en_out       = wr_en_q;
  assign wr_bank_out     = wr_bank_q;
  assign wr_addr_out     = wr_addr_q;
  assign wr_data_out     = wr_data_q;
  assign rd_bank_out     = rd_bank_q;
  assign frame_ready_out = frame_ready_q;
  assign busy_out        = busy_q;
  assign drop_count_out  = drop_count_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: a small-geometry instance for frame-level
// behaviour and a default-geometry instance for full-range address checks.
`timescale 1ns/1ps
module tb_frame_capture_ctrl;

  localparam int H  = 6;
  localparam int V  = 4;
  localparam int N  = H * V;
  localparam int DH = 320;
  localparam int DV = 240;

  logic        clk = 1'b0;
  logic        rst_n, capture_req, continuous, frame_done, data_valid, rd_lock;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [15:0] pixel;

  logic        s_wr_en, s_wr_bank, s_rd_bank, s_frame_ready, s_busy;
  logic [16:0] s_wr_addr;
  logic [15:0] s_wr_data;
  logic [7:0]  s_drops;
  logic        d_wr_en, d_wr_bank, d_rd_bank, d_frame_ready, d_busy;
  logic [16:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic [7:0]  d_drops;

  always #7.692 clk = ~clk;

  frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) u_small (
    .system_clk_in(clk), .rst_n_in(rst_n), .capture_req_in(capture_req),
    .continuous_in(continuous), .frame_done_in(frame_done), .data_valid_in(data_valid),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_in(pixel), .rd_lock_in(rd_lock),
    .wr_en_out(s_wr_en), .wr_bank_out(s_wr_bank), .wr_addr_out(s_wr_addr),
    .wr_data_out(s_wr_data), .rd_bank_out(s_rd_bank), .frame_ready_out(s_frame_ready),
    .busy_out(s_busy), .drop_count_out(s_drops)
  );

  frame_capture_ctrl u_dflt (
    .system_clk_in(clk), .rst_n_in(rst_n), .capture_req_in(capture_req),
    .continuous_in(continuous), .frame_done_in(frame_done), .data_valid_in(data_valid),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_in(pixel), .rd_lock_in(rd_lock),
    .wr_en_out(d_wr_en), .wr_bank_out(d_wr_bank), .wr_addr_out(d_wr_addr),
    .wr_data_out(d_wr_data), .rd_bank_out(d_rd_bank), .frame_ready_out(d_frame_ready),
    .busy_out(d_busy), .drop_count_out(d_drops)
  );

  typedef struct packed {
    logic        bank;
    logic [16:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$], act_q[$], exp_d_q[$], act_d_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: capture mode flags plus frame bookkeeping.
  bit   m_armed, m_capturing, d_track;
  int   m_count, m_drops, m_ready_exp;
  int   ready_seen = 0;
  logic m_wr_bank, m_rd_bank;

  always @(negedge clk) begin
    if (s_wr_en) act_q.push_back({s_wr_bank, s_wr_addr, s_wr_data});
    if (s_frame_ready) ready_seen++;
    if (d_track && d_wr_en) act_d_q.push_back({d_wr_bank, d_wr_addr, d_wr_data});
  end

  function automatic int first_diff(input wr_t a[$], input wr_t b[$], input bit use_bank);
    int lim;
    lim = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < lim; i++) begin
      if (a[i].addr !== b[i].addr || a[i].data !== b[i].data ||
          (use_bank && a[i].bank !== b[i].bank)) return i;
    end
    if (a.size() != b.size()) return lim;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_armed = 0; m_capturing = 0; m_count = 0; m_drops = 0;
    m_wr_bank = 1'b0; m_rd_bank = 1'b1;
    m_ready_exp = ready_seen;
    exp_q.delete(); act_q.delete(); exp_d_q.delete(); act_d_q.delete();
  endtask

  task automatic apply_reset();
    capture_req = 0; continuous = 0; frame_done = 0; data_valid = 0; rd_lock = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #2 model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    tick();
  endtask

  task automatic drive_req();
    capture_req = 1;
    tick();
    capture_req = 0;
    if (!m_armed && !m_capturing) m_armed = 1;
  endtask

  task automatic drive_pixel(input int h, input int v, input logic [15:0] p);
    hcount = 11'(h); vcount = 10'(v); pixel = p; data_valid = 1;
    tick();
    data_valid = 0;
    if (m_capturing && h < H && v < V) begin
      exp_q.push_back({m_wr_bank, 17'(v * H + h), p});
      m_count++;
    end
    if (d_track && m_capturing && h < DH && v < DV)
      exp_d_q.push_back({1'b0, 17'(v * DH + h), p});
  endtask

  // End of frame; optionally with a coincident pixel that must be discarded.
  task automatic drive_fd(input bit with_px, input int h, input int v);
    frame_done = 1;
    if (with_px) begin
      hcount = 11'(h); vcount = 10'(v); pixel = 16'($urandom); data_valid = 1;
    end
    tick();
    frame_done = 0; data_valid = 0;
    if (m_capturing) begin
      if (m_count == N && !rd_lock) begin
        m_rd_bank = m_wr_bank;
        m_wr_bank = ~m_wr_bank;
        m_ready_exp++;
      end else if (m_drops < 255) begin
        m_drops++;
      end
      m_count = 0;
      if (!continuous) m_capturing = 0;
    end else if (m_armed) begin
      m_armed = 0; m_capturing = 1; m_count = 0;
    end
    tick();
    tick();
  endtask

  task automatic send_oor();
    if ($urandom_range(0, 1)) drive_pixel($urandom_range(H, H + 8), $urandom_range(0, V - 1), 16'($urandom));
    else                      drive_pixel($urandom_range(0, H - 1), $urandom_range(V, V + 8), 16'($urandom));
  endtask

  // len in-range pixels, raster order or random coordinates, with optional noise.
  task automatic send_frame(input int len, input bit raster, input bit noise);
    for (int k = 0; k < len; k++) begin
      if (noise && $urandom_range(0, 5) == 0) send_oor();
      if (noise && $urandom_range(0, 5) == 0) tick();
      if (raster) drive_pixel(k % H, (k / H) % V, 16'($urandom));
      else        drive_pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1), 16'($urandom));
    end
  endtask

  task automatic test_reset();
    int d;
    apply_reset();
    n_cmp++;
    if (s_rd_bank !== 1'b1 || s_wr_bank !== 1'b0) begin
      n_err++; $display("FAIL reset_banks: got rd=%0b wr=%0b want rd=1 wr=0", s_rd_bank, s_wr_bank);
    end
    drive_req();
    n_cmp++;
    if (s_busy !== 1'b1) begin n_err++; $display("FAIL req_busy: got %0b want 1", s_busy); end
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    n_cmp++;
    if (s_busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %0b want 0", s_busy); end
    n_cmp++;
    if (s_wr_en !== 1'b0 || s_wr_addr !== 17'd0 || s_wr_data !== 16'd0) begin
      n_err++; $display("FAIL async_wr: got en=%0b addr=%0d data=%h want 0/0/0", s_wr_en, s_wr_addr, s_wr_data);
    end
    n_cmp++;
    if (s_wr_bank !== 1'b0 || s_rd_bank !== 1'b1 || s_frame_ready !== 1'b0 || s_drops !== 8'd0) begin
      n_err++; $display("FAIL async_misc: got wb=%0b rb=%0b rdy=%0b drops=%0d want 0/1/0/0",
                        s_wr_bank, s_rd_bank, s_frame_ready, s_drops);
    end
    // Request present only at the first edge after release must be missed.
    repeat (2) @(posedge clk);
    #3 rst_n = 1; capture_req = 1;
    @(posedge clk);
    #1 capture_req = 0;
    tick();
    n_cmp++;
    if (s_busy !== 1'b0) begin n_err++; $display("FAIL release_edge1: got busy=%0b want 0", s_busy); end
    // Request at the second edge after release must be taken.
    @(posedge clk);
    #3 rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    capture_req = 1;
    tick();
    capture_req = 0;
    n_cmp++;
    if (s_busy !== 1'b1) begin n_err++; $display("FAIL release_edge2: got busy=%0b want 1", s_busy); end
    d = 0;
  endtask

  task automatic test_single_capture();
    int d;
    apply_reset();
    drive_req();
    drive_fd(0, 0, 0);
    send_frame(N, 1, 1);
    drive_fd(0, 0, 0);
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL single_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
    n_cmp++;
    if (act_q.size() == 0 || act_q[act_q.size() - 1].addr !== 17'(N - 1)) begin
      n_err++; $display("FAIL single_last_addr: got %0d writes, want last addr %0d", act_q.size(), N - 1);
    end
    n_cmp++;
    if (ready_seen !== m_ready_exp) begin
      n_err++; $display("FAIL single_ready: got %0d pulses want %0d", ready_seen, m_ready_exp);
    end
    n_cmp++;
    if (s_rd_bank !== m_rd_bank || s_wr_bank !== m_wr_bank || s_busy !== 1'b0) begin
      n_err++; $display("FAIL single_state: got rb=%0b wb=%0b busy=%0b want rb=%0b wb=%0b busy=0",
                        s_rd_bank, s_wr_bank, s_busy, m_rd_bank, m_wr_bank);
    end
  endtask

  task automatic test_alignment();
    int d;
    apply_reset();
    drive_req();
    send_frame(100, 0, 0);
    n_cmp++;
    if (act_q.size() != 0) begin
      n_err++; $display("FAIL align_presof: got %0d writes want 0", act_q.size());
    end
    drive_fd(0, 0, 0);
    send_frame(N, 0, 1);
    drive_fd(0, 0, 0);
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL align_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
    n_cmp++;
    if (ready_seen !== m_ready_exp || s_rd_bank !== m_rd_bank) begin
      n_err++; $display("FAIL align_publish: got rdy=%0d rb=%0b want rdy=%0d rb=%0b",
                        ready_seen, s_rd_bank, m_ready_exp, m_rd_bank);
    end
  endtask

  task automatic test_short_collision();
    int d;
    apply_reset();
    drive_req();
    drive_fd(0, 0, 0);
    send_frame(N - 1, 1, 0);
    drive_fd(1, H - 1, V - 1);
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL short_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
    n_cmp++;
    if (s_drops !== 8'(m_drops) || ready_seen !== m_ready_exp) begin
      n_err++; $display("FAIL short_drop: got drops=%0d rdy=%0d want drops=%0d rdy=%0d",
                        s_drops, ready_seen, m_drops, m_ready_exp);
    end
    n_cmp++;
    if (s_wr_bank !== m_wr_bank || s_rd_bank !== m_rd_bank) begin
      n_err++; $display("FAIL short_banks: got wb=%0b rb=%0b want wb=%0b rb=%0b",
                        s_wr_bank, s_rd_bank, m_wr_bank, m_rd_bank);
    end
  endtask

  task automatic test_range_continuous();
    int d;
    apply_reset();
    continuous = 1;
    drive_req();
    drive_fd(0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      drive_pixel(H, 0, 16'($urandom));
      send_frame(N, 1, 1);
      drive_pixel(0, V, 16'($urandom));
      if (f == 2) continuous = 0;
      drive_fd(0, 0, 0);
      n_cmp++;
      if (s_wr_bank !== m_wr_bank || s_rd_bank !== m_rd_bank) begin
        n_err++; $display("FAIL cont_bank f%0d: got wb=%0b rb=%0b want wb=%0b rb=%0b",
                          f, s_wr_bank, s_rd_bank, m_wr_bank, m_rd_bank);
      end
    end
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL cont_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
    n_cmp++;
    if (ready_seen !== m_ready_exp || s_busy !== 1'b0) begin
      n_err++; $display("FAIL cont_ready: got rdy=%0d busy=%0b want rdy=%0d busy=0", ready_seen, s_busy, m_ready_exp);
    end
  endtask

  task automatic test_default_addr();
    int d;
    apply_reset();
    d_track = 1;
    drive_req();
    drive_fd(0, 0, 0);
    drive_pixel(DH - 1, DV - 1, 16'hBEEF);
    drive_pixel(DH, 0, 16'($urandom));
    drive_pixel(0, DV, 16'($urandom));
    drive_pixel(0, 0, 16'($urandom));
    drive_pixel(DH - 1, 0, 16'($urandom));
    drive_pixel(0, DV - 1, 16'($urandom));
    for (int k = 0; k < 6; k++)
      drive_pixel($urandom_range(0, DH + 20), $urandom_range(0, DV + 20), 16'($urandom));
    drive_fd(0, 0, 0);
    d_track = 0;
    n_cmp++;
    if (act_d_q.size() == 0 || act_d_q[0].addr !== 17'd76799 || act_d_q[0].data !== 16'hBEEF) begin
      n_err++; $display("FAIL dflt_max_addr: got %0d writes, want first addr 76799 data beef", act_d_q.size());
    end
    d = first_diff(act_d_q, exp_d_q, 0);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL dflt_writes: diff at %0d, got %0d writes want %0d", d, act_d_q.size(), exp_d_q.size());
    end
  endtask

  task automatic test_lock_drop();
    int d;
    apply_reset();
    rd_lock = 1;
    drive_req();
    drive_fd(0, 0, 0);
    send_frame(N, 1, 0);
    drive_fd(0, 0, 0);
    n_cmp++;
    if (s_drops !== 8'(m_drops) || ready_seen !== m_ready_exp ||
        s_wr_bank !== m_wr_bank || s_rd_bank !== m_rd_bank) begin
      n_err++; $display("FAIL lock_first: got drops=%0d rdy=%0d wb=%0b rb=%0b want %0d/%0d/%0b/%0b",
                        s_drops, ready_seen, s_wr_bank, s_rd_bank, m_drops, m_ready_exp, m_wr_bank, m_rd_bank);
    end
    continuous = 1;
    drive_req();
    drive_fd(0, 0, 0);
    for (int i = 0; i < 299; i++) begin
      send_frame(N, 1, 0);
      if (i == 298) continuous = 0;
      drive_fd(0, 0, 0);
    end
    rd_lock = 0;
    n_cmp++;
    if (s_drops !== 8'(m_drops)) begin
      n_err++; $display("FAIL lock_saturate: got drops=%0d want %0d", s_drops, m_drops);
    end
    n_cmp++;
    if (ready_seen !== m_ready_exp || s_wr_bank !== m_wr_bank) begin
      n_err++; $display("FAIL lock_nopublish: got rdy=%0d wb=%0b want rdy=%0d wb=%0b",
                        ready_seen, s_wr_bank, m_ready_exp, m_wr_bank);
    end
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL lock_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_capture();
    int d;
    apply_reset();
    drive_req();
    drive_fd(0, 0, 0);
    send_frame(499, 0, 0);
    hcount = 11'($urandom_range(0, H - 1)); vcount = 10'($urandom_range(0, V - 1));
    pixel = 16'($urandom); data_valid = 1;
    @(posedge clk);
    #1 rst_n = 0; data_valid = 0;
    #1;
    n_cmp++;
    if (s_wr_en !== 1'b0 || s_wr_addr !== 17'd0 || s_wr_data !== 16'd0 || s_busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: got en=%0b addr=%0d data=%h busy=%0b want 0/0/0/0",
                        s_wr_en, s_wr_addr, s_wr_data, s_busy);
    end
    n_cmp++;
    if (s_wr_bank !== 1'b0 || s_rd_bank !== 1'b1 || s_drops !== 8'd0 || s_frame_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_banks: got wb=%0b rb=%0b drops=%0d rdy=%0b want 0/1/0/0",
                        s_wr_bank, s_rd_bank, s_drops, s_frame_ready);
    end
    repeat (2) @(posedge clk);
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL midrst_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
    #3 rst_n = 1;
    repeat (4) tick();
    n_cmp++;
    if (s_busy !== 1'b0 || s_drops !== 8'd0 || ready_seen !== m_ready_exp) begin
      n_err++; $display("FAIL midrst_idle: got busy=%0b drops=%0d rdy=%0d want 0/0/%0d",
                        s_busy, s_drops, ready_seen, m_ready_exp);
    end
  endtask

  task automatic test_random();
    int d, len, pick;
    apply_reset();
    for (int it = 0; it < 25; it++) begin
      if (!m_capturing) begin
        drive_req();
        repeat ($urandom_range(0, 5)) drive_pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1), 16'($urandom));
        if ($urandom_range(0, 1)) drive_req();
        drive_fd(0, 0, 0);
      end
      pick = $urandom_range(0, 4);
      len  = (pick == 0) ? N - 1 : (pick == 3) ? N + 1 : (pick == 4) ? $urandom_range(0, N + 3) : N;
      send_frame(len, 0, 1);
      if ($urandom_range(0, 3) == 0) drive_req();
      rd_lock    = ($urandom_range(0, 3) == 0);
      continuous = 1'($urandom_range(0, 1));
      drive_fd(0, 0, 0);
      n_cmp++;
      if (s_wr_bank !== m_wr_bank || s_rd_bank !== m_rd_bank) begin
        n_err++; $display("FAIL rand_banks it%0d: got wb=%0b rb=%0b want wb=%0b rb=%0b",
                          it, s_wr_bank, s_rd_bank, m_wr_bank, m_rd_bank);
      end
      n_cmp++;
      if (s_drops !== 8'(m_drops) || ready_seen !== m_ready_exp) begin
        n_err++; $display("FAIL rand_counts it%0d: got drops=%0d rdy=%0d want drops=%0d rdy=%0d",
                          it, s_drops, ready_seen, m_drops, m_ready_exp);
      end
      n_cmp++;
      if (s_busy !== m_capturing) begin
        n_err++; $display("FAIL rand_busy it%0d: got %0b want %0b", it, s_busy, m_capturing);
      end
    end
    continuous = 0; rd_lock = 0;
    if (m_capturing) drive_fd(0, 0, 0);
    d = first_diff(act_q, exp_q, 1);
    n_cmp++;
    if (d != -1) begin
      n_err++; $display("FAIL rand_writes: diff at %0d, got %0d writes want %0d", d, act_q.size(), exp_q.size());
    end
  endtask

  initial begin
    rst_n = 0; capture_req = 0; continuous = 0; frame_done = 0; data_valid = 0; rd_lock = 0;
    hcount = '0; vcount = '0; pixel = '0; d_track = 0;
    test_reset();
    test_single_capture();
    test_alignment();
    test_short_collision();
    test_range_continuous();
    test_default_addr();
    test_lock_drop();
    test_reset_mid_capture();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
